// File: rtl/comp_pkg.sv
// comp_pkg: shared constants and FSM state type for the compensation drain path
package comp_pkg;
    localparam int COMP_W        = 14;
    localparam int N_COL_DEFAULT = 8;
    typedef enum logic [0:0] {IDLE = 1'b0, DRAIN = 1'b1} comp_rd_state_t;
endpackage

// File: rtl/comp_shadow_bank.sv
// comp_shadow_bank: parallel-load snapshot of all column sums with an indexed read port
module comp_shadow_bank
    import comp_pkg::*;
#(
    parameter int N_COL  = N_COL_DEFAULT,
    parameter int DATA_W = COMP_W,
    parameter int IDX_W  = $clog2(N_COL)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [N_COL*DATA_W-1:0] i_data,
    input  logic [IDX_W-1:0]        i_idx,
    output logic [DATA_W-1:0]       o_data
);
    logic [DATA_W-1:0] r_mem [N_COL];

    // capture every column in one cycle; cleared on reset so the read port idles at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_COL; i++) r_mem[i] <= '0;
        end else if (i_load) begin
            for (int i = 0; i < N_COL; i++) r_mem[i] <= i_data[i*DATA_W +: DATA_W];
        end
    end

    assign o_data = r_mem[i_idx];
endmodule

// File: rtl/compensation_readout.sv
// compensation_readout: snapshots compensation sums and streams them one column per cycle
module compensation_readout
    import comp_pkg::*;
#(
    parameter int N_COL  = N_COL_DEFAULT,
    parameter int DATA_W = COMP_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      capture,
    input  logic [N_COL*DATA_W-1:0]   comp_sum_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_COL)-1:0]  out_col,
    output logic                      out_last,
    output logic                      busy,
    output logic                      capture_drop
);
    localparam int IDX_W = $clog2(N_COL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COL - 1);

    comp_rd_state_t   r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_drop;
    logic             w_draining;
    logic             w_last;
    logic             w_xfer;
    logic             w_load;

    assign w_draining = (r_state == DRAIN);
    assign w_last     = w_draining && (r_idx == LAST_IDX);
    assign w_xfer     = w_draining && out_ready;
    // a capture landing on the final handshake chains straight into the next tile
    assign w_load     = capture && (!w_draining || (w_last && out_ready));

    comp_shadow_bank #(
        .N_COL  (N_COL),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (comp_sum_in),
        .i_idx  (r_idx),
        .o_data (out_data)
    );

    // drain FSM, column index and rejected-capture flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= capture && !w_load;
            if (w_load) begin
                r_state <= DRAIN;
                r_idx   <= '0;
            end else if (w_xfer) begin
                if (w_last) r_state <= IDLE;
                else        r_idx   <= r_idx + 1'b1;
            end
        end
    end

    assign out_valid    = w_draining;
    assign busy         = w_draining;
    assign out_last     = w_last;
    assign out_col      = r_idx;
    assign capture_drop = r_drop;
endmodule

// File: tb/tb_compensation_readout.sv
// tb_compensation_readout: directed and randomized checks of the compensation drain stream
module tb_compensation_readout;
    localparam int N  = 8;
    localparam int W  = 14;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           capture;
    logic [N*W-1:0] comp_sum_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_col;
    logic           out_last;
    logic           busy;
    logic           capture_drop;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] tile [N];
    logic [W-1:0] old  [N];
    logic [W-1:0] m_data [$];
    int           m_col  [$];
    bit           m_drop;

    compensation_readout #(.N_COL(N), .DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .comp_sum_in  (comp_sum_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy),
        .capture_drop (capture_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic pack_tile;
        for (int c = 0; c < N; c++) comp_sum_in[c*W +: W] = tile[c];
    endtask

    task automatic rand_tile;
        for (int c = 0; c < N; c++) tile[c] = W'($urandom);
        pack_tile();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        capture = 1'b0;
        out_ready = 1'b0;
        comp_sum_in = '0;
        #3;
        checks++;
        if ({out_valid, out_last, busy, capture_drop} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got v/l/b/d=%b exp 0000", {out_valid, out_last, busy, capture_drop});
        end
        checks++;
        if ({out_data, out_col} !== '0) begin
            errors++;
            $display("FAIL reset_data got data=%h col=%0d exp 0/0", out_data, out_col);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_basic_drain;
        for (int c = 0; c < N; c++) tile[c] = W'(c + 1);
        tile[N-1] = 14'h3FFF;
        pack_tile();
        capture = 1'b1;
        out_ready = 1'b1;
        cyc();
        capture = 1'b0;
        for (int b = 0; b < N; b++) begin
            checks++;
            if ({out_valid, busy, out_last, out_col, out_data} !== {1'b1, 1'b1, b == N-1, IW'(b), tile[b]}) begin
                errors++;
                $display("FAIL basic_beat%0d got v=%b b=%b l=%b col=%0d data=%h exp 1 1 %b %0d %h",
                         b, out_valid, busy, out_last, out_col, out_data, b == N-1, b, tile[b]);
            end
            cyc();
        end
        checks++;
        if ({out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic_end got valid=%b busy=%b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure;
        int idx = 0;
        rand_tile();
        capture = 1'b1;
        out_ready = 1'b1;
        cyc();
        capture = 1'b0;
        for (int k = 0; k < 40 && idx < N; k++) begin
            out_ready = (k % 4 == 0) || (k % 4 == 3);
            checks++;
            if ({out_valid, out_col, out_data} !== {1'b1, IW'(idx), tile[idx]}) begin
                errors++;
                $display("FAIL bp_cycle%0d got v=%b col=%0d data=%h exp 1 %0d %h",
                         k, out_valid, out_col, out_data, idx, tile[idx]);
            end
            if (out_ready) idx++;
            cyc();
        end
        out_ready = 1'b1;
        checks++;
        if (idx != N || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got delivered=%0d valid=%b exp %0d 0", idx, out_valid, N);
        end
    endtask

    task automatic test_reject;
        rand_tile();
        capture = 1'b1;
        out_ready = 1'b1;
        cyc();
        for (int b = 0; b < N; b++) begin
            capture = (b == 2);
            if (b == 2) comp_sum_in = {N{14'h1111}};
            checks++;
            if ({out_valid, out_col, out_data, capture_drop} !== {1'b1, IW'(b), tile[b], b == 3}) begin
                errors++;
                $display("FAIL reject_beat%0d got v=%b col=%0d data=%h drop=%b exp 1 %0d %h %b",
                         b, out_valid, out_col, out_data, capture_drop, b, tile[b], b == 3);
            end
            cyc();
        end
        capture = 1'b0;
        checks++;
        if ({busy, capture_drop} !== 2'b00) begin
            errors++;
            $display("FAIL reject_end got busy=%b drop=%b exp 0 0", busy, capture_drop);
        end
    endtask

    task automatic test_chained;
        rand_tile();
        capture = 1'b1;
        out_ready = 1'b1;
        cyc();
        capture = 1'b0;
        old = tile;
        for (int b = 0; b < N; b++) begin
            checks++;
            if ({busy, out_col, out_data, capture_drop} !== {1'b1, IW'(b), old[b], 1'b0}) begin
                errors++;
                $display("FAIL chain_a%0d got b=%b col=%0d data=%h drop=%b exp 1 %0d %h 0",
                         b, busy, out_col, out_data, capture_drop, b, old[b]);
            end
            if (b == N-1) begin
                rand_tile();
                capture = 1'b1;
            end
            cyc();
            capture = 1'b0;
        end
        for (int b = 0; b < N; b++) begin
            checks++;
            if ({busy, out_col, out_data, capture_drop} !== {1'b1, IW'(b), tile[b], 1'b0}) begin
                errors++;
                $display("FAIL chain_b%0d got b=%b col=%0d data=%h drop=%b exp 1 %0d %h 0",
                         b, busy, out_col, out_data, capture_drop, b, tile[b]);
            end
            cyc();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL chain_end got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        rand_tile();
        capture = 1'b1;
        out_ready = 1'b1;
        cyc();
        capture = 1'b0;
        repeat (3) cyc();
        checks++;
        if ({out_valid, out_col} !== {1'b1, IW'(3)}) begin
            errors++;
            $display("FAIL rstmid_pre got v=%b col=%0d exp 1 3", out_valid, out_col);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_last, busy, capture_drop, out_data, out_col} !== '0) begin
            errors++;
            $display("FAIL rstmid_async got v=%b l=%b b=%b d=%b data=%h col=%0d exp all 0",
                     out_valid, out_last, busy, capture_drop, out_data, out_col);
        end
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({out_valid, busy} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_after%0d got valid=%b busy=%b exp 0 0", k, out_valid, busy);
            end
            cyc();
        end
    endtask

    task automatic test_random;
        bit xfer;
        bit acc;
        m_data.delete();
        m_col.delete();
        m_drop = 1'b0;
        for (int k = 0; k < 400 || m_data.size() > 0; k++) begin
            checks++;
            if ({out_valid, busy, capture_drop} !== {m_data.size() > 0, m_data.size() > 0, m_drop}) begin
                errors++;
                $display("FAIL rand_flags%0d got v=%b b=%b d=%b exp %b %b %b", k, out_valid, busy,
                         capture_drop, m_data.size() > 0, m_data.size() > 0, m_drop);
            end
            if (m_data.size() > 0) begin
                checks++;
                if ({out_data, out_col, out_last} !== {m_data[0], IW'(m_col[0]), m_col[0] == N-1}) begin
                    errors++;
                    $display("FAIL rand_beat%0d got data=%h col=%0d last=%b exp %h %0d %b", k, out_data,
                             out_col, out_last, m_data[0], m_col[0], m_col[0] == N-1);
                end
            end
            capture = (k < 400) && ($urandom_range(3) == 0);
            if (capture) rand_tile();
            out_ready = (k >= 400) || ($urandom_range(3) != 0);
            xfer = (m_data.size() > 0) && out_ready;
            acc = capture && (m_data.size() == 0 || (m_data.size() == 1 && out_ready));
            m_drop = capture && !acc;
            if (xfer) begin
                void'(m_data.pop_front());
                void'(m_col.pop_front());
            end
            if (acc) begin
                for (int c = 0; c < N; c++) begin
                    m_data.push_back(tile[c]);
                    m_col.push_back(c);
                end
            end
            cyc();
            if (k > 2000) begin
                checks++;
                errors++;
                $display("FAIL rand_timeout got pending=%0d exp 0", m_data.size());
                break;
            end
        end
        capture = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_reject();
        test_chained();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/compensation_readout.md
# compensation_readout

Drain side of the compensation path. Snapshots the 14-bit running sums of all compensation accumulators in one cycle on a capture pulse. Streams the sums out one column per cycle over a valid/ready interface toward the output buffer / partial-sum merger. The accumulators can resume on the next tile while the previous tile's sums drain.

## Interface
Parameters:
- `N_COL`, default 8: number of accumulator columns; must be at least 2.
- `DATA_W`, default 14: width of one compensation sum.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `capture`, in, 1: one-cycle request to snapshot `comp_sum_in`.
- `comp_sum_in`, in, `N_COL*DATA_W`: packed accumulator outputs. Column c occupies bits `[c*DATA_W +: DATA_W]`.
- `out_valid`, out, 1: `out_data` holds a valid sum.
- `out_ready`, in, 1: downstream accepts the sum.
- `out_data`, out, `DATA_W`: the current column's sum.
- `out_col`, out, `$clog2(N_COL)`: index of the current column.
- `out_last`, out, 1: the current beat is column `N_COL-1`.
- `busy`, out, 1: high while draining.
- `capture_drop`, out, 1: one-cycle pulse when a capture is rejected.

## Operation
- FSM has two states: IDLE and DRAIN. Shadow bank holds `N_COL` words of `DATA_W` bits. Column index `idx` runs from 0 to `N_COL-1`.
- **IDLE, `capture`=1:**
  - load all columns into the shadow bank;
  - set `idx`=0 and go to DRAIN.
- **DRAIN:**
  - `out_valid`=1, `out_data`=shadow[`idx`], `out_col`=`idx`;
  - `out_last`=1 when `idx`==`N_COL-1`.
- **Handshake:** a beat transfers when `out_valid` and `out_ready` are both high on a rising edge.
  - Not last beat: `idx` increments.
  - Last beat: go to IDLE.
- **Backpressure:** with `out_ready`=0, `out_data`, `out_col` and `out_last` hold stable. `out_valid` never drops until the beat transfers.
- **Capture during DRAIN:**
  - The capture is ignored and the shadow bank is untouched.
  - `capture_drop` pulses high for one cycle on the following cycle.
  - Exception: capture in the same cycle as the last-beat handshake is accepted. The shadow bank reloads, `idx` becomes 0, and the FSM stays in DRAIN with no idle bubble.
- **Data:** sums pass through bit-exact. No sign or saturation handling.
- **Reset:** asynchronous, effective immediately, including mid-drain. After reset:
  - FSM is IDLE and `idx`=0;
  - `out_valid`, `out_last`, `busy` and `capture_drop` are 0;
  - `out_data` and `out_col` are 0;
  - the shadow bank is cleared to 0;
  - a partially drained tile is discarded.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from `out_ready` or `capture` to any output.
- Capture at edge k: `out_valid`, `busy` and column 0 are visible from edge k to edge k+1.
- Full throughput: with `out_ready` held at 1, the `N_COL` beats occupy `N_COL` consecutive cycles.
- Back-to-back captures timed on the last beat give a continuous stream.
- `busy` equals (state==DRAIN).
- `capture_drop` is asserted in the cycle after the rejected capture, for exactly one cycle.

## Structure
- Shared package `comp_pkg`:
  - `COMP_W` = 14 and `N_COL_DEFAULT` = 8;
  - state enum `comp_rd_state_t` with values IDLE and DRAIN.
- One sub-module, `comp_shadow_bank`: a parallel-load register array with a read mux indexed by `idx`.
- The FSM, index counter and handshake logic stay in the top module.

## Test plan
- **Basic drain:** reset; columns 0..7 = 1..8 (column 7 = 0x3FFF); capture; `out_ready`=1.
  - Beats arrive in cycles 1..8 with values 1..7 then 0x3FFF and `out_col` 0..7.
  - `out_last` is high only on beat 8; `busy` falls after beat 8.
- **Backpressure:** toggle `out_ready` in a 1-0-0-1 pattern during a drain.
  - Every value is delivered exactly once, in order.
  - Data holds stable while `out_ready`=0.
- **Rejected capture:** capture during beat 3 with new input 0x1111 in all columns.
  - `capture_drop` pulses one cycle later.
  - The remaining beats still carry the original sums.
- **Chained capture:** capture coincides with the last handshake.
  - The next cycle shows column 0 of the new snapshot.
  - `busy` never drops and `capture_drop` stays 0.
- **Reset mid-drain:** assert `rst` during beat 4.
  - All outputs go to 0 immediately.
  - After reset release, with no new capture, `out_valid` stays 0.
